// File: rtl/wash_pkg.sv
// Shared encodings and timing helpers for the washer program sequencer.
// State and program codes are plain constants so legacy display drivers can decode them.
package wash_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FILL  = 4'd1;
  localparam logic [3:0] ST_WASH  = 4'd2;
  localparam logic [3:0] ST_RINSE = 4'd3;
  localparam logic [3:0] ST_DRAIN = 4'd4;
  localparam logic [3:0] ST_SPIN  = 4'd5;
  localparam logic [3:0] ST_DONE  = 4'd6;

  localparam logic [2:0] PROG_WRS  = 3'd0;
  localparam logic [2:0] PROG_W    = 3'd1;
  localparam logic [2:0] PROG_WR   = 3'd2;
  localparam logic [2:0] PROG_R    = 3'd3;
  localparam logic [2:0] PROG_RS   = 3'd4;
  localparam logic [2:0] PROG_S    = 3'd5;
  localparam logic [2:0] PROG_LAST = PROG_S;

  typedef enum logic [1:0] {SEG_WASH, SEG_RINSE, SEG_SPIN} seg_e;

  typedef struct packed {
    logic has_wash;
    logic has_rinse;
    logic has_spin;
  } seg_mask_t;

  function automatic seg_mask_t seg_mask(input logic [2:0] prog);
    seg_mask_t m;
    case (prog)
      PROG_WRS: m = 3'b111;
      PROG_W:   m = 3'b100;
      PROG_WR:  m = 3'b110;
      PROG_R:   m = 3'b010;
      PROG_RS:  m = 3'b011;
      PROG_S:   m = 3'b001;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic int unsigned phase_duration(input logic [3:0] st, input int unsigned level,
                                                 input int unsigned wash_t, input int unsigned rinse_t,
                                                 input int unsigned spin_t, input int unsigned max_v);
    int unsigned d;
    case (st)
      ST_FILL, ST_DRAIN: d = level;
      ST_WASH:           d = wash_t;
      ST_RINSE:          d = rinse_t;
      ST_SPIN:           d = spin_t;
      default:           d = 0;
    endcase
    return (d > max_v) ? max_v : d;
  endfunction

  function automatic int unsigned total_time(input logic [2:0] prog, input int unsigned level,
                                             input int unsigned wash_t, input int unsigned rinse_t,
                                             input int unsigned spin_t, input int unsigned rinse_cnt,
                                             input int unsigned max_v);
    seg_mask_t m;
    longint unsigned sum;
    m   = seg_mask(prog);
    sum = 64'd0;
    if (m.has_wash)  sum = sum + 64'(level) * 64'd2 + 64'(wash_t);
    if (m.has_rinse) sum = sum + 64'(rinse_cnt) * (64'(level) * 64'd2 + 64'(rinse_t));
    if (m.has_spin)  sum = sum + 64'(spin_t);
    return (sum > 64'(max_v)) ? max_v : 32'(sum);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Tick-gated phase and program down-counters with load, reload-on-terminal and clear.
module wash_phase_timer #(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              count,
  input  logic              clear,
  input  logic [TIME_W-1:0] phase_val,
  input  logic [TIME_W-1:0] total_val,
  output logic [TIME_W-1:0] phase_left,
  output logic [TIME_W-1:0] total_left,
  output logic              phase_done
);

  logic [TIME_W-1:0] phase_left_reg;
  logic [TIME_W-1:0] total_left_reg;

  assign phase_done = (phase_left_reg == TIME_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase_left_reg <= '0;
      total_left_reg <= '0;
    end else if (load) begin
      phase_left_reg <= phase_val;
      total_left_reg <= total_val;
    end else if (count) begin
      // The terminal tick reloads with the following phase's length.
      phase_left_reg <= phase_done ? phase_val : phase_left_reg - TIME_W'(1);
      if (total_left_reg != '0) total_left_reg <= total_left_reg - TIME_W'(1);
    end
  end

  assign phase_left = phase_left_reg;
  assign total_left = total_left_reg;

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: wash/rinse/spin segments timed on an external tick.
// Optional door interlock (adds door_open) is enabled by defining WASH_DOOR_INTERLOCK_EN.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int WEIGHT_W     = 3,
  parameter int MAX_WEIGHT   = 6,
  parameter int LEVEL_PER_KG = 2,
  parameter int LEVEL_W      = 8,
  parameter int TIME_W       = 8,
  parameter int WASH_T       = 9,
  parameter int RINSE_T      = 6,
  parameter int SPIN_T       = 3,
  parameter int RINSE_CNT    = 1,
  parameter int BEEP_TICKS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_pause,
  input  logic                mode_next,
`ifdef WASH_DOOR_INTERLOCK_EN
  input  logic                door_open,
`endif
  input  logic [WEIGHT_W-1:0] weight,
  // Selected program; `program` is a reserved word, hence program_sel.
  output logic [2:0]          program_sel,
  output logic [3:0]          state,
  output logic                running,
  output logic                paused,
  output logic                wash_led,
  output logic                rinse_led,
  output logic                spin_led,
  output logic                fill_valve,
  output logic                drain_valve,
  output logic [LEVEL_W-1:0]  water_level,
  output logic [TIME_W-1:0]   phase_left,
  output logic [TIME_W-1:0]   total_left,
  output logic                done_beep
);

  localparam int unsigned TIME_MAX   = 32'((64'd1 << TIME_W) - 64'd1);
  localparam logic [7:0]  RINSE_INIT = 8'(RINSE_CNT);
  localparam logic [7:0]  BEEP_INIT  = 8'(BEEP_TICKS);

  logic [3:0]         state_reg;
  logic [2:0]         program_reg;
  logic               paused_reg;
  seg_e               seg_reg;
  logic [7:0]         rinse_left_reg;
  logic [LEVEL_W-1:0] level_tgt_reg;
  logic [LEVEL_W-1:0] water_level_reg;
  logic [7:0]         beep_cnt_reg;
  logic               parity_reg;

  logic               door_block;
  logic               active;
  logic               start_go;
  logic               count;
  logic               phase_done;
  logic [WEIGHT_W-1:0] weff;
  logic [LEVEL_W-1:0] level_now;
  logic [LEVEL_W-1:0] level_sel;
  seg_mask_t          mask;
  logic [3:0]         first_state, adv_state, sel_state;
  seg_e               first_seg, adv_seg;
  logic [7:0]         adv_rinse_left;
  logic [TIME_W-1:0]  phase_val, total_val;

`ifdef WASH_DOOR_INTERLOCK_EN
  assign door_block = door_open;
`else
  assign door_block = 1'b0;
`endif

  assign active   = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign start_go = !active && start_pause && !door_block;
  assign count    = active && tick && !paused_reg;
  assign mask     = seg_mask(program_reg);

  assign weff = (weight == '0) ? WEIGHT_W'(1) :
                (int'(weight) > MAX_WEIGHT) ? WEIGHT_W'(MAX_WEIGHT) : weight;
  assign level_now = LEVEL_W'(int'(weff) * LEVEL_PER_KG);
  assign level_sel = active ? level_tgt_reg : level_now;

  always_comb begin
    first_state = ST_SPIN;
    first_seg   = SEG_SPIN;
    if (mask.has_wash) begin
      first_state = ST_FILL;
      first_seg   = SEG_WASH;
    end else if (mask.has_rinse) begin
      first_state = ST_FILL;
      first_seg   = SEG_RINSE;
    end
  end

  always_comb begin
    adv_state      = state_reg;
    adv_seg        = seg_reg;
    adv_rinse_left = rinse_left_reg;
    case (state_reg)
      ST_FILL:           adv_state = (seg_reg == SEG_RINSE) ? ST_RINSE : ST_WASH;
      ST_WASH, ST_RINSE: adv_state = ST_DRAIN;
      ST_DRAIN: begin
        if (seg_reg == SEG_WASH && mask.has_rinse) begin
          adv_state      = ST_FILL;
          adv_seg        = SEG_RINSE;
          adv_rinse_left = RINSE_INIT;
        end else if (seg_reg == SEG_RINSE && rinse_left_reg > 8'd1) begin
          adv_state      = ST_FILL;
          adv_rinse_left = rinse_left_reg - 8'd1;
        end else if (mask.has_spin) begin
          adv_state = ST_SPIN;
          adv_seg   = SEG_SPIN;
        end else begin
          adv_state = ST_DONE;
        end
      end
      ST_SPIN: adv_state = ST_DONE;
      default: adv_state = state_reg;
    endcase
  end

  assign sel_state = active ? adv_state : first_state;
  assign phase_val = TIME_W'(phase_duration(sel_state, 32'(level_sel), WASH_T, RINSE_T, SPIN_T, TIME_MAX));
  assign total_val = TIME_W'(total_time(program_reg, 32'(level_now), WASH_T, RINSE_T, SPIN_T,
                                        RINSE_CNT, TIME_MAX));

  wash_phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (start_go),
    .count      (count),
    .clear      (count && phase_done && (adv_state == ST_DONE)),
    .phase_val  (phase_val),
    .total_val  (total_val),
    .phase_left (phase_left),
    .total_left (total_left),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      program_reg     <= PROG_WRS;
      paused_reg      <= 1'b0;
      seg_reg         <= SEG_WASH;
      rinse_left_reg  <= '0;
      level_tgt_reg   <= '0;
      water_level_reg <= '0;
      beep_cnt_reg    <= '0;
      parity_reg      <= 1'b0;
    end else begin
      if (tick) parity_reg <= ~parity_reg;
      if (!active) begin
        if (start_go) begin
          state_reg      <= first_state;
          seg_reg        <= first_seg;
          rinse_left_reg <= RINSE_INIT;
          level_tgt_reg  <= level_now;
          paused_reg     <= 1'b0;
          beep_cnt_reg   <= '0;
        end else if (mode_next) begin
          program_reg  <= (program_reg == PROG_LAST) ? PROG_WRS : program_reg + 3'd1;
          state_reg    <= ST_IDLE;
          beep_cnt_reg <= '0;
        end else if (state_reg == ST_DONE && tick && beep_cnt_reg != '0) begin
          beep_cnt_reg <= beep_cnt_reg - 8'd1;
        end
      end else begin
        // An open door holds the pause and masks any attempt to resume.
        if (door_block)       paused_reg <= 1'b1;
        else if (start_pause) paused_reg <= ~paused_reg;
        if (count) begin
          if (state_reg == ST_FILL)
            water_level_reg <= water_level_reg + LEVEL_W'(1);
          else if (state_reg == ST_DRAIN && water_level_reg != '0)
            water_level_reg <= water_level_reg - LEVEL_W'(1);
          if (phase_done) begin
            state_reg      <= adv_state;
            seg_reg        <= adv_seg;
            rinse_left_reg <= adv_rinse_left;
            if (adv_state == ST_DONE) begin
              water_level_reg <= '0;
              beep_cnt_reg    <= BEEP_INIT;
            end
          end
        end
      end
    end
  end

  logic blink;
  logic wet_phase;
  assign blink     = !paused_reg || parity_reg;
  assign wet_phase = (state_reg == ST_FILL) || (state_reg == ST_WASH) ||
                     (state_reg == ST_RINSE) || (state_reg == ST_DRAIN);

  assign program_sel = program_reg;
  assign state       = state_reg;
  assign running     = active;
  assign paused      = paused_reg;
  assign wash_led    = wet_phase && (seg_reg == SEG_WASH) && blink;
  assign rinse_led   = wet_phase && (seg_reg == SEG_RINSE) && blink;
  assign spin_led    = (state_reg == ST_SPIN) && blink;
  assign fill_valve  = (state_reg == ST_FILL) && !paused_reg;
  assign drain_valve = (state_reg == ST_DRAIN) && !paused_reg;
  assign water_level = water_level_reg;
  assign done_beep   = (beep_cnt_reg != '0);

endmodule
